// File: rtl/fpu_divider.sv
// Sequential IEEE-754 single-precision divider. The mantissa is divided by
// restoring division at one quotient bit per clock. Results are truncated.
module fpu_divider #(
  parameter int D_WIDTH = 32,
  parameter int M_WIDTH = 23,
  parameter int E_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [D_WIDTH-1:0] number_1,
  input  logic [D_WIDTH-1:0] number_2,
  output logic [D_WIDTH-1:0] number_out,
  output logic               valid,
  output logic               busy,
  output logic               div_by_zero
);

  localparam int SW = M_WIDTH + 1;
  localparam int QW = M_WIDTH + 2;
  localparam int CW = $clog2(QW);
  localparam int XW = E_WIDTH + 2;
  localparam logic [CW-1:0] LAST_STEP = CW'(QW - 1);
  localparam logic [XW-1:0] BIAS      = XW'((1 << (E_WIDTH - 1)) - 1);
  localparam logic [XW-1:0] EXP_SAT   = XW'((1 << E_WIDTH) - 1);

  typedef enum logic [1:0] {IDLE, CALC, NORM} state_t;
  state_t state, state_next;

  logic               sign_q, dbz_q, zero_q;
  logic [E_WIDTH-1:0] exp1_q, exp2_q;
  logic [SW-1:0]      div_q;
  logic [QW-1:0]      rem_q, quo_q, rem_diff;
  logic [CW-1:0]      step_q;

  logic               sign_in, special_in;
  logic [E_WIDTH-1:0] exp1_in, exp2_in;

  logic [XW-1:0]      exp_calc;
  logic [M_WIDTH-1:0] mant_calc;
  logic [D_WIDTH-1:0] result;

  assign sign_in    = number_1[D_WIDTH-1] ^ number_2[D_WIDTH-1];
  assign exp1_in    = number_1[D_WIDTH-2 -: E_WIDTH];
  assign exp2_in    = number_2[D_WIDTH-2 -: E_WIDTH];
  assign special_in = (exp1_in == '0) || (exp2_in == '0);
  assign busy       = (state != IDLE);
  assign rem_diff   = rem_q - {1'b0, div_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = special_in ? NORM : CALC;
      CALC:    if (step_q == LAST_STEP) state_next = NORM;
      NORM:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The quotient lies in (0.5, 2): its top bit decides the one-place normalisation.
  always_comb begin
    result    = '0;
    exp_calc  = {2'b00, exp1_q} - {2'b00, exp2_q} + BIAS
                - {{(XW-1){1'b0}}, ~quo_q[QW-1]};
    mant_calc = quo_q[QW-1] ? quo_q[QW-2:1] : quo_q[QW-3:0];
    if (dbz_q)
      result = {sign_q, {E_WIDTH{1'b1}}, {M_WIDTH{1'b0}}};
    else if (zero_q)
      result = {sign_q, {(D_WIDTH-1){1'b0}}};
    else if (exp_calc[XW-1] || (exp_calc == '0))
      result = {sign_q, {(D_WIDTH-1){1'b0}}};
    else if (exp_calc >= EXP_SAT)
      result = {sign_q, {E_WIDTH{1'b1}}, {M_WIDTH{1'b0}}};
    else
      result = {sign_q, exp_calc[E_WIDTH-1:0], mant_calc};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      number_out  <= '0;
      valid       <= 1'b0;
      div_by_zero <= 1'b0;
      sign_q      <= 1'b0;
      dbz_q       <= 1'b0;
      zero_q      <= 1'b0;
      exp1_q      <= '0;
      exp2_q      <= '0;
      div_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      step_q      <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign_q <= sign_in;
            exp1_q <= exp1_in;
            exp2_q <= exp2_in;
            dbz_q  <= (exp2_in == '0);
            zero_q <= (exp1_in == '0);
            div_q  <= {1'b1, number_2[M_WIDTH-1:0]};
            rem_q  <= {2'b01, number_1[M_WIDTH-1:0]};
            quo_q  <= '0;
            step_q <= '0;
          end
        end
        CALC: begin
          if (rem_q >= {1'b0, div_q}) begin
            quo_q <= {quo_q[QW-2:0], 1'b1};
            rem_q <= {rem_diff[QW-2:0], 1'b0};
          end else begin
            quo_q <= {quo_q[QW-2:0], 1'b0};
            rem_q <= {rem_q[QW-2:0], 1'b0};
          end
          step_q <= step_q + CW'(1);
        end
        NORM: begin
          number_out  <= result;
          div_by_zero <= dbz_q;
          valid       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_divider.sv
// Self-checking bench for fpu_divider: integer-division reference model,
// per-cycle output comparison, directed corner cases and random operands.
module tb_fpu_divider;

  logic        clk, rst_n, start;
  logic [31:0] number_1, number_2, number_out;
  logic        valid, busy, div_by_zero;

  int errors = 0;
  int checks = 0;

  int          m_remain;
  logic [31:0] m_out, m_pend;
  bit          m_valid, m_dbz, m_pend_dbz;

  fpu_divider #(.D_WIDTH(32), .M_WIDTH(23), .E_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .number_1(number_1), .number_2(number_2),
    .number_out(number_out), .valid(valid), .busy(busy),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Quotient from plain integer division of the scaled significands.
  function automatic void refDiv(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] res, output bit dbz);
    bit         s;
    int         ea, eb, e;
    longint     na, nb, q;
    logic [22:0] mant;
    s   = a[31] ^ b[31];
    ea  = int'(a[30:23]);
    eb  = int'(b[30:23]);
    dbz = 1'b0;
    if (eb == 0) begin
      res = {s, 8'hFF, 23'h0};
      dbz = 1'b1;
      return;
    end
    if (ea == 0) begin
      res = {s, 31'h0};
      return;
    end
    na = (longint'(1) << 23) | longint'(a[22:0]);
    nb = (longint'(1) << 23) | longint'(b[22:0]);
    q  = (na << 24) / nb;
    if (q >= (longint'(1) << 24)) begin
      e    = ea - eb + 127;
      mant = q[23:1];
    end else begin
      e    = ea - eb + 126;
      mant = q[22:0];
    end
    if (e >= 255)    res = {s, 8'hFF, 23'h0};
    else if (e <= 0) res = {s, 31'h0};
    else             res = {s, e[7:0], mant};
  endfunction

  function automatic logic [31:0] randOperand();
    logic [7:0] e;
    case ($urandom_range(0, 9))
      0:       e = 8'h00;
      1:       e = 8'hFF;
      2:       e = 8'($urandom_range(0, 255));
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  task automatic modelReset();
    m_remain = 0;
    m_valid  = 1'b0;
    m_out    = '0;
    m_dbz    = 1'b0;
  endtask

  // One accepted operation is in flight for 26 edges, or 1 edge for special operands.
  task automatic modelStep();
    if (!rst_n) begin
      modelReset();
      return;
    end
    m_valid = 1'b0;
    if (m_remain == 0) begin
      if (start) begin
        refDiv(number_1, number_2, m_pend, m_pend_dbz);
        m_remain = (number_1[30:23] == 8'h00 || number_2[30:23] == 8'h00) ? 1 : 26;
      end
    end else begin
      m_remain--;
      if (m_remain == 0) begin
        m_valid = 1'b1;
        m_out   = m_pend;
        m_dbz   = m_pend_dbz;
      end
    end
  endtask

  task automatic compareCycle();
    checkOutput("cyc_valid", 32'(valid), 32'(m_valid));
    checkOutput("cyc_busy", 32'(busy), 32'(m_remain != 0));
    checkOutput("cyc_number_out", number_out, m_out);
    checkOutput("cyc_div_by_zero", 32'(div_by_zero), 32'(m_dbz));
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    compareCycle();
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    number_1 = a;
    number_2 = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Waits for valid; lat counts edges after the one that sampled start.
  task automatic waitResult(input int poke_at, input bit noise, output int lat);
    bit ok;
    lat = 0;
    ok  = 1'b0;
    while (lat < 40) begin
      if (valid) begin
        ok = 1'b1;
        break;
      end
      if (lat == poke_at || (noise && $urandom_range(0, 3) == 0)) begin
        start    = 1'b1;
        number_1 = $urandom;
        number_2 = $urandom;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    if (!ok) checkOutput("result_timeout", 32'(valid), 32'd1);
  endtask

  task automatic runCase(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] want, input bit want_dbz,
                         input int want_lat, input int poke_at);
    logic [31:0] mres;
    bit          mdbz;
    int          lat;
    refDiv(a, b, mres, mdbz);
    checkOutput({name, "_model"}, mres, want);
    applyStimulus(a, b);
    waitResult(poke_at, 1'b0, lat);
    checkOutput({name, "_latency"}, lat, want_lat);
    checkOutput({name, "_out"}, number_out, want);
    checkOutput({name, "_dbz"}, 32'(div_by_zero), 32'(want_dbz));
  endtask

  task automatic checkCleared(input string name);
    checkOutput({name, "_out"}, number_out, 32'h0);
    checkOutput({name, "_valid"}, 32'(valid), 32'd0);
    checkOutput({name, "_busy"}, 32'(busy), 32'd0);
    checkOutput({name, "_dbz"}, 32'(div_by_zero), 32'd0);
  endtask

  initial begin
    int lat;
    int gap;
    logic [31:0] a, b;
    start    = 1'b0;
    number_1 = '0;
    number_2 = '0;
    rst_n    = 1'b1;
    modelReset();
    #1 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checkCleared("reset");

    runCase("div_6_2",       32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 26, -1);
    runCase("div_1_3",       32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 26, -1);
    runCase("div_m7p5_2p5",  32'hC0F00000, 32'h40200000, 32'hC0400000, 1'b0, 26, -1);
    runCase("div_by_zero",   32'h40A00000, 32'h00000000, 32'h7F800000, 1'b1, 1, -1);
    runCase("zero_dividend", 32'h00000000, 32'h40000000, 32'h00000000, 1'b0, 1, -1);
    runCase("zero_by_zero",  32'h80000000, 32'h00000000, 32'hFF800000, 1'b1, 1, -1);
    runCase("overflow",      32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b0, 26, -1);
    runCase("underflow",     32'h00800000, 32'h4B000000, 32'h00000000, 1'b0, 26, -1);
    runCase("ignore_start",  32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 26, 4);

    // Reset in the middle of CALC discards the operation.
    applyStimulus(32'h3F800000, 32'h40400000);
    repeat (8) tick();
    #2 rst_n = 1'b0;
    modelReset();
    #1 checkCleared("mid_reset");
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (30) tick();
    runCase("after_reset",   32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 26, -1);

    for (int i = 0; i < 40; i++) begin
      a   = randOperand();
      b   = randOperand();
      gap = $urandom_range(0, 2);
      repeat (gap) tick();
      applyStimulus(a, b);
      waitResult(-1, 1'($urandom_range(0, 1)), lat);
    end
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
